// File: rtl/pic_priority_resolver_n.sv
`default_nettype none
// ============================================================================
// Module   : pic_priority_resolver_n
// Purpose  : 8259A-style priority resolver, N channels, nested or rotating
//            priority. Optional special mask mode: PIC_SPECIAL_MASK_MODE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pic_priority_resolver_n #(
    parameter int N_IRQ = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irr,
    input  logic [N_IRQ-1:0] imr,
    input  logic [N_IRQ-1:0] isr,
    input  logic             freeze,
    input  logic             mode_rotate,
    input  logic             rotate_valid,
    input  logic [IDX_W-1:0] rotate_idx,
    input  logic             set_prio_valid,
    input  logic [IDX_W-1:0] set_prio_idx,
`ifdef PIC_SPECIAL_MASK_MODE_EN
    input  logic             smm,
`endif
    output logic             int_req,
    output logic [IDX_W-1:0] resolved_idx,
    output logic             resolved_valid,
    output logic [IDX_W-1:0] lowest_prio
);

    localparam logic [IDX_W-1:0] c_LOWEST_RST = IDX_W'(N_IRQ - 1);
    localparam logic [IDX_W:0]   c_N_IRQ      = (IDX_W + 1)'(N_IRQ);

    logic [N_IRQ-1:0] r_latch;
    logic [IDX_W-1:0] r_lowest;
    logic             r_int_req;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;

    logic [N_IRQ-1:0] w_isr_eff;
    logic [IDX_W-1:0] w_cand_idx;
    int               w_cand_rank;
    int               w_svc_rank;
    logic             w_svc_found;
    logic             w_valid;
    logic             w_int_req;

    // Rank 0 is the highest priority: the channel just after the pointer.
    function automatic int rank_of(input int k, input logic [IDX_W-1:0] lowest);
        int r;
        r = k - int'(lowest) - 1;
        if (r < 0) r = r + N_IRQ;
        return r;
    endfunction

    always_comb begin
`ifdef PIC_SPECIAL_MASK_MODE_EN
        w_isr_eff = smm ? (isr & ~imr) : isr;
`else
        w_isr_eff = isr;
`endif
    end

    always_comb begin
        w_cand_idx  = '0;
        w_cand_rank = N_IRQ;
        w_svc_rank  = N_IRQ;
        w_svc_found = 1'b0;
        for (int k = 0; k < N_IRQ; k++) begin
            if (r_latch[k] && (rank_of(k, r_lowest) < w_cand_rank)) begin
                w_cand_rank = rank_of(k, r_lowest);
                w_cand_idx  = IDX_W'(k);
            end
            if (w_isr_eff[k] && (rank_of(k, r_lowest) < w_svc_rank)) begin
                w_svc_rank  = rank_of(k, r_lowest);
                w_svc_found = 1'b1;
            end
        end
        w_valid   = (r_latch != '0);
        // Equal level is not enough: the request must strictly outrank service.
        w_int_req = w_valid && (!w_svc_found || (w_cand_rank < w_svc_rank));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_latch   <= '0;
            r_int_req <= 1'b0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
        end else if (!freeze) begin
            r_latch   <= irr & ~imr;
            r_int_req <= w_int_req;
            r_idx     <= w_cand_idx;
            r_valid   <= w_valid;
        end
    end

    // Pointer keeps tracking commands during freeze; out-of-range indices hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lowest <= c_LOWEST_RST;
        end else if (!mode_rotate) begin
            r_lowest <= c_LOWEST_RST;
        end else if (set_prio_valid) begin
            if ({1'b0, set_prio_idx} < c_N_IRQ) r_lowest <= set_prio_idx;
        end else if (rotate_valid) begin
            if ({1'b0, rotate_idx} < c_N_IRQ) r_lowest <= rotate_idx;
        end
    end

    assign int_req        = r_int_req;
    assign resolved_idx   = r_idx;
    assign resolved_valid = r_valid;
    assign lowest_prio    = r_lowest;

endmodule
`default_nettype wire

// File: tb/tb_pic_priority_resolver_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_priority_resolver_n
// Purpose  : Scoreboard bench for pic_priority_resolver_n (8- and 5-channel).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pic_priority_resolver_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: 8 channels
    logic [7:0] irr_a = '0, imr_a = '0, isr_a = '0;
    logic       freeze_a = 0, mode_rotate_a = 0, rotate_valid_a = 0, set_prio_valid_a = 0;
    logic [2:0] rotate_idx_a = '0, set_prio_idx_a = '0;
    logic       smm_a = 0;
    logic       int_req_a, resolved_valid_a;
    logic [2:0] resolved_idx_a, lowest_prio_a;

    // DUT B: 5 channels, 3-bit index so out-of-range values are expressible
    logic [4:0] irr_b = '0, imr_b = '0, isr_b = '0;
    logic       freeze_b = 0, mode_rotate_b = 0, rotate_valid_b = 0, set_prio_valid_b = 0;
    logic [2:0] rotate_idx_b = '0, set_prio_idx_b = '0;
    logic       smm_b = 0;
    logic       int_req_b, resolved_valid_b;
    logic [2:0] resolved_idx_b, lowest_prio_b;

    pic_priority_resolver_n #(.N_IRQ(8), .IDX_W(3)) u_dut_a (
        .clk(clk), .rst(rst), .irr(irr_a), .imr(imr_a), .isr(isr_a),
        .freeze(freeze_a), .mode_rotate(mode_rotate_a),
        .rotate_valid(rotate_valid_a), .rotate_idx(rotate_idx_a),
        .set_prio_valid(set_prio_valid_a), .set_prio_idx(set_prio_idx_a),
`ifdef PIC_SPECIAL_MASK_MODE_EN
        .smm(smm_a),
`endif
        .int_req(int_req_a), .resolved_idx(resolved_idx_a),
        .resolved_valid(resolved_valid_a), .lowest_prio(lowest_prio_a)
    );

    pic_priority_resolver_n #(.N_IRQ(5), .IDX_W(3)) u_dut_b (
        .clk(clk), .rst(rst), .irr(irr_b), .imr(imr_b), .isr(isr_b),
        .freeze(freeze_b), .mode_rotate(mode_rotate_b),
        .rotate_valid(rotate_valid_b), .rotate_idx(rotate_idx_b),
        .set_prio_valid(set_prio_valid_b), .set_prio_idx(set_prio_idx_b),
`ifdef PIC_SPECIAL_MASK_MODE_EN
        .smm(smm_b),
`endif
        .int_req(int_req_b), .resolved_idx(resolved_idx_b),
        .resolved_valid(resolved_valid_b), .lowest_prio(lowest_prio_b)
    );

    typedef struct {
        int    due;
        bit    dut_b;
        bit    ir;
        int    idx;
        bit    v;
        int    low;
        string nm;
    } exp_t;

    exp_t sb[$];

    task automatic expect_o(input bit dut_b, input int dly, input bit ir, input int idx,
                            input bit v, input int low, input string nm);
        exp_t e;
        e.due = cyc + dly; e.dut_b = dut_b; e.ir = ir; e.idx = idx;
        e.v = v; e.low = low; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every negedge, retire scoreboard entries due this cycle.
    int   mi;
    bit   a_ir, a_v;
    int   a_idx, a_low;
    always @(negedge clk) begin
        mi = 0;
        while (mi < sb.size()) begin
            if (sb[mi].due <= cyc) begin
                if (sb[mi].dut_b) begin
                    a_ir = int_req_b; a_v = resolved_valid_b;
                    a_idx = int'(resolved_idx_b); a_low = int'(lowest_prio_b);
                end else begin
                    a_ir = int_req_a; a_v = resolved_valid_a;
                    a_idx = int'(resolved_idx_a); a_low = int'(lowest_prio_a);
                end
                n_tests++;
                if (sb[mi].due < cyc) begin
                    n_fail++;
                    $display("FAIL %s: check missed its cycle (due %0d, now %0d)",
                             sb[mi].nm, sb[mi].due, cyc);
                end else if (a_ir != sb[mi].ir || a_v != sb[mi].v ||
                             a_idx != sb[mi].idx || a_low != sb[mi].low) begin
                    n_fail++;
                    $display("FAIL %s: got int_req=%0d idx=%0d valid=%0d lowest=%0d, want int_req=%0d idx=%0d valid=%0d lowest=%0d",
                             sb[mi].nm, a_ir, a_idx, a_v, a_low,
                             sb[mi].ir, sb[mi].idx, sb[mi].v, sb[mi].low);
                end
                sb.delete(mi);
            end else begin
                mi++;
            end
        end
    end

    initial begin
        // Reset values while rst is held
        step(2);
        expect_o(0, 0, 0, 0, 0, 7, "rst_a");
        expect_o(1, 0, 0, 0, 0, 4, "rst_b");
        step(1);
        rst = 1'b0;
        expect_o(0, 2, 0, 0, 0, 7, "idle");
        step(2);

        // Fully nested mode
        irr_a = 8'b0010_1000;
        expect_o(0, 1, 0, 0, 0, 7, "fn_latency");
        expect_o(0, 2, 1, 3, 1, 7, "fn_irq3");
        step(2);
        isr_a = 8'b0000_1000;
        expect_o(0, 1, 0, 3, 1, 7, "fn_same_level");
        step(2);
        irr_a = 8'b0010_1010;
        expect_o(0, 1, 0, 3, 1, 7, "fn_latency2");
        expect_o(0, 2, 1, 1, 1, 7, "fn_preempt");
        step(2);
        irr_a = 8'h00;
        expect_o(0, 2, 0, 0, 0, 7, "isr_only");
        step(2);

        // Rotation: pointer 3 -> order 4..7,0,1,2,3
        isr_a = 8'h00; mode_rotate_a = 1; rotate_valid_a = 1; rotate_idx_a = 3;
        irr_a = 8'b0000_0101;
        expect_o(0, 2, 1, 0, 1, 3, "rot3");
        step(1);
        rotate_valid_a = 0;
        step(1);
        set_prio_valid_a = 1; set_prio_idx_a = 0; rotate_valid_a = 1; rotate_idx_a = 5;
        expect_o(0, 2, 1, 2, 1, 0, "setprio_wins");
        step(1);
        set_prio_valid_a = 0; rotate_valid_a = 0;
        step(1);
        mode_rotate_a = 0; rotate_valid_a = 1; rotate_idx_a = 2;
        expect_o(0, 1, 1, 2, 1, 7, "nested_ptr");
        expect_o(0, 2, 1, 0, 1, 7, "nested_restore");
        step(1);
        rotate_valid_a = 0;
        step(1);

        // Freeze
        irr_a = 8'b0001_0000;
        expect_o(0, 2, 1, 4, 1, 7, "frz_setup");
        step(2);
        freeze_a = 1; irr_a = 8'b0000_0001;
        expect_o(0, 2, 1, 4, 1, 7, "frz_hold");
        expect_o(0, 3, 1, 4, 1, 7, "frz_hold2");
        step(3);
        freeze_a = 0;
        expect_o(0, 1, 1, 4, 1, 7, "frz_release_lat");
        expect_o(0, 2, 1, 0, 1, 7, "frz_release");
        step(2);

        // Masking
        imr_a = 8'hFF; irr_a = 8'hFF;
        expect_o(0, 2, 0, 0, 0, 7, "all_masked");
        step(2);
        imr_a = 8'h07;
        expect_o(0, 2, 1, 3, 1, 7, "part_masked");
        step(2);

        // Masked in-service level
        imr_a = 8'b0000_0010; isr_a = 8'b0000_0010; irr_a = 8'b0010_0000;
`ifdef PIC_SPECIAL_MASK_MODE_EN
        smm_a = 1;
        expect_o(0, 2, 1, 5, 1, 7, "smm_on");
        step(2);
        smm_a = 0;
        expect_o(0, 1, 0, 5, 1, 7, "smm_off");
        step(2);
`else
        expect_o(0, 2, 0, 5, 1, 7, "isr_masked_blocks");
        step(2);
`endif
        irr_a = '0; imr_a = '0; isr_a = '0;

        // DUT B: range checks and mod-5 wrap
        mode_rotate_b = 1; rotate_valid_b = 1; rotate_idx_b = 6;
        step(1);
        rotate_valid_b = 0; set_prio_valid_b = 1; set_prio_idx_b = 5;
        step(1);
        set_prio_valid_b = 0;
        expect_o(1, 1, 0, 0, 0, 4, "b_range_ignored");
        step(1);
        irr_b = 5'b10001;
        expect_o(1, 2, 1, 0, 1, 4, "b_wrap");
        step(2);
        set_prio_valid_b = 1; set_prio_idx_b = 1;
        expect_o(1, 2, 1, 4, 1, 1, "b_setprio1");
        step(1);
        set_prio_valid_b = 0;
        step(1);
        isr_b = 5'b00001;
        expect_o(1, 1, 1, 4, 1, 1, "b_isr_lower");
        step(2);
        isr_b = 5'b00100;
        expect_o(1, 1, 0, 4, 1, 1, "b_isr_higher");
        step(2);

        // Asynchronous reset mid-operation
        irr_a = 8'h10;
        step(2);
        rst = 1'b1;
        expect_o(0, 0, 0, 0, 0, 7, "async_rst_a");
        expect_o(1, 0, 0, 0, 0, 4, "async_rst_b");
        step(2);
        rst = 1'b0;
        step(3);

        while (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: never checked (due %0d)", sb[0].nm, sb[0].due);
            void'(sb.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/pic_priority_resolver_n.md
Name: pic_priority_resolver_n

Overview:
- Clocked, parametrised priority resolver for the 8259A-compatible PIC. Supports N interrupt channels and two modes: fully nested and automatic/specific rotation.
- Sits between the IRR/IMR/ISR registers and the control logic.
- Each cycle it picks the highest-priority unmasked pending request and compares it against the highest in-service level. It raises int_req only when the pending request outranks everything in service.
- Holds a registered rotation pointer, a freeze latch and registered outputs.

Parameters:
N_IRQ, 8, number of interrupt channels (2..32)
IDX_W, 3, index width; must satisfy 2**IDX_W >= N_IRQ

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
irr  in  N_IRQ  interrupt request register contents
imr  in  N_IRQ  interrupt mask register (1 = masked)
isr  in  N_IRQ  in-service register contents
freeze  in  1  1 = hold sampled requests (INTA sequence in progress)
mode_rotate  in  1  1 = rotation mode, 0 = fully nested
rotate_valid  in  1  single-cycle pulse: rotate so rotate_idx becomes lowest priority (rotate-on-EOI)
rotate_idx  in  IDX_W  IR that becomes lowest priority
set_prio_valid  in  1  single-cycle pulse: set-priority command
set_prio_idx  in  IDX_W  IR that becomes lowest priority
int_req  out  1  registered interrupt request to control logic
resolved_idx  out  IDX_W  registered index of winning request
resolved_valid  out  1  registered: a non-masked request is pending
lowest_prio  out  IDX_W  current lowest-priority IR (rotation pointer)

Behaviour:
- Reset (async, any time): lowest_prio=N_IRQ-1, int_req=0, resolved_idx=0, resolved_valid=0, request latch=0. Reset asserted mid-operation aborts all state; first evaluation happens on the first rising edge after rst deasserts.
- Request latch: each cycle with freeze=0, latch <= irr & ~imr. With freeze=1, latch holds its value, and resolved_idx/resolved_valid/int_req hold as well.
- Priority order: highest priority is (lowest_prio+1) mod N_IRQ, descending cyclically through lowest_prio. Modulo wrap uses N_IRQ, not 2**IDX_W.
- Resolution (combinational from latch, isr, lowest_prio; registered into outputs):
  - cand = highest-priority set bit of latch.
  - svc = highest-priority set bit of isr.
  - resolved_valid = (latch != 0).
  - resolved_idx = cand, or 0 if none.
  - int_req = resolved_valid and (isr == 0 or cand strictly higher priority than svc).
  - A request at the same level as svc does not raise int_req.
- Latency: irr change to int_req/resolved_idx is 2 cycles (latch, then output register). isr or lowest_prio change to outputs is 1 cycle.
- Pointer update, in priority order per cycle:
  1. mode_rotate=0: lowest_prio <= N_IRQ-1 every cycle; rotate_valid and set_prio_valid are ignored.
  2. Else if set_prio_valid: lowest_prio <= set_prio_idx.
  3. Else if rotate_valid: lowest_prio <= rotate_idx.
  4. Else hold.
- Pointer updates are applied even while freeze=1; outputs reflect them after freeze drops.
- Index range: an idx >= N_IRQ on set_prio_idx/rotate_idx is ignored and the pointer holds.
- Simultaneous set_prio_valid and rotate_valid: set_prio_valid wins.
- All-masked or no requests: resolved_valid=0, int_req=0, resolved_idx=0.
- ISR bits set with no pending request: int_req=0.

Optional Feature:
- Macro: PIC_SPECIAL_MASK_MODE_EN.
- Defined: adds input smm (1 bit). When smm=1, svc is computed from isr & ~imr, so masked in-service levels stop blocking lower-priority requests. When smm=0, behaviour is identical to the build without the macro.
- Undefined: no smm port; svc is always computed from the full isr.

Test Plan:
- Reset then idle: rst pulse, irr=0 -> int_req=0, resolved_valid=0, lowest_prio=7.
- Fully nested: mode_rotate=0, irr=8'b0010_1000, isr=0 -> after 2 cycles int_req=1, resolved_idx=3. Then isr=8'b0000_1000 -> int_req=0. Then irr adds bit 1 -> resolved_idx=1, int_req=1.
- Rotation: mode_rotate=1, rotate_valid with rotate_idx=3, irr=8'b0000_0101 -> lowest_prio=3; priority order 4,5,6,7,0,1,2,3 -> resolved_idx=0. Next set_prio_valid with idx=0 and rotate_valid with idx=5 in the same cycle -> lowest_prio=0, resolved_idx=2.
- Freeze: resolved_idx=4 with freeze=1, then irr changes to 8'b0000_0001 -> outputs hold idx 4. Drop freeze -> 2 cycles later resolved_idx=0.
- Masking and ranges: imr=8'hFF with irr=8'hFF -> resolved_valid=0, int_req=0. With N_IRQ=5 build, rotate_idx=6 -> pointer unchanged. With N_IRQ=5 and lowest_prio=4, irr bit0 -> resolved_idx=0 (wrap at 5).
- With PIC_SPECIAL_MASK_MODE_EN, smm=1: isr=8'b0000_0010, imr=8'b0000_0010, irr=8'b0010_0000 -> int_req=1, resolved_idx=5. With smm=0 -> int_req=0.
